cpu_trace_buffer: RTL and testbench
===================================

// Module: cpu_trace_buffer
// PURPOSE
//  Parametrised on-chip trace capture for the single-cycle CPU: samples curPC, op and ALUData each enabled cycle
//  into a circular buffer, with PC-match trigger and programmable post-trigger depth.
//  Sits beside the CPU core and replaces waveform-only observation of those signals.
//  Captured window is drained oldest-first through a valid/ready read port.
// PARAMETERS
//  DATA_W  32  width of curPC, trig_pc, ALUData and rd_pc/rd_alu
//  OP_W    6   width of op / rd_op
//  DEPTH   16  entries in buffer; power of two, >=2
//  CNT_W   $clog2(DEPTH)+1  width of count, post_count (derived, do not override)
// PORTS
//  CLK         in   1       clock, all state updates on rising edge
//  Reset       in   1       asynchronous, active-low reset
//  arm         in   1       1-cycle pulse: clear buffer and (re)start capture
//  mode        in   1       0 = trigger immediately on arm; 1 = trigger on curPC==trig_pc
//  trig_pc     in   DATA_W  trigger PC (mode 1)
//  post_count  in   CNT_W   samples stored after trigger sample; latched on arm
//  sample_en   in   1       qualifies curPC/op/ALUData as a valid sample this cycle
//  curPC       in   DATA_W  CPU current PC
//  op          in   OP_W    CPU opcode
//  ALUData     in   DATA_W  CPU ALU result
//  rd_ready    in   1       consumer accepts rd_* this cycle
//  rd_valid    out  1       rd_* hold the oldest unread entry
//  rd_pc       out  DATA_W  entry PC
//  rd_op       out  OP_W    entry opcode
//  rd_alu      out  DATA_W  entry ALU result
//  count       out  CNT_W   entries held (0..DEPTH)
//  state       out  2       00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE
//  overflow    out  1       sticky: an entry was overwritten since last arm
// BEHAVIOUR
//  - Reset low: state=IDLE, count=0, wr/rd pointers=0, overflow=0, rd_valid=0, rd_*=0; buffer contents don't-care.
//  - rd_pc/rd_op/rd_alu are forced to 0 whenever rd_valid=0.
//  - arm=1 in any state (highest priority, wins over sample/read same cycle): count=0, pointers=0, overflow=0,
//    latch post_count into post_rem; next state ARMED. No sample is written in the arm cycle.
//  - IDLE: ignores sample_en and rd_ready.
//  - ARMED: each sample_en cycle writes {curPC,op,ALUData} at wr_ptr, wr_ptr+1 mod DEPTH, count+1 saturating
//    at DEPTH; write at count==DEPTH overwrites oldest and sets overflow.
//    Trigger = sample_en && (mode==0 || curPC==trig_pc); trigger sample is written as above.
//    On trigger: post_rem==0 -> DONE; else -> CAPTURE. mode is sampled each cycle, not latched.
//  - CAPTURE: each sample_en cycle writes (same overwrite rules) and decrements post_rem; write that takes
//    post_rem 1->0 moves to DONE the same edge. Further PC matches ignored.
//  - post_count >= DEPTH legal: buffer keeps only last DEPTH samples, overflow=1, trigger sample may be lost.
//  - DONE: no writes. rd_valid = (count!=0). rd_* = entry at rd_ptr = (wr_ptr - count) mod DEPTH, combinational
//    from storage (zero-latency). rd_valid&&rd_ready pops: count-1. Stays DONE at count 0 until arm.
//  - rd_valid is 0 in IDLE/ARMED/CAPTURE regardless of count.
//  - Reset asserted mid-capture or mid-drain: immediate return to reset values; no partial state survives.
//  - Pointer arithmetic modulo DEPTH via natural wrap of $clog2(DEPTH)-bit pointers.
// TESTING (DEPTH=8)
//  1 reset: Reset=0 with random inputs -> state=00, count=0, rd_valid=0, rd_*=0, overflow=0.
//  2 immediate: mode=0, post_count=2, arm, sample PCs 0x00,0x04,0x08 -> DONE after 3rd, count=3, drain 0x00,0x04,0x08.
//  3 PC trigger: mode=1, trig_pc=0x20, post=1, PCs 0x00..0x24 step 4 -> count=8? no: 10 samples -> count=8,
//    overflow=1, drain 0x08..0x24 in order.
//  4 post_count=0, mode=1, trig_pc=0x0C -> DONE on the 0x0C sample; last drained entry rd_pc=0x0C.
//  5 drain backpressure: DONE count=3, rd_ready toggles 1,0,1,1 -> exactly 3 pops, rd_* stable while rd_ready=0.
//  6 re-arm mid-drain and Reset low mid-CAPTURE -> count=0, overflow=0; state ARMED / IDLE respectively.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - on-chip circular trace capture of CPU PC/op/ALU with PC trigger and post-trigger depth
module cpu_trace_buffer #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 6,
   parameter int DEPTH  = 16,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              arm,
   input  logic              mode,
   input  logic [DATA_W-1:0] trig_pc,
   input  logic [CNT_W-1:0]  post_count,
   input  logic              sample_en,
   input  logic [DATA_W-1:0] curPC,
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] ALUData,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_pc,
   output logic [OP_W-1:0]   rd_op,
   output logic [DATA_W-1:0] rd_alu,
   output logic [CNT_W-1:0]  count,
   output logic [1:0]        state,
   output logic              overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = 2 * DATA_W + OP_W;

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_ARMED   = 2'b01,
      S_CAPTURE = 2'b10,
      S_DONE    = 2'b11
   } state_t;

   state_t            cur_state;
   state_t            nxt_state;
   logic [ENT_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  post_rem;
   logic [ENT_W-1:0]  rd_entry;
   logic              wr_en;
   logic              pop;
   logic              post_dec;
   logic              full;

   assign state    = cur_state;
   assign full     = (count == CNT_W'(DEPTH));
   assign rd_valid = (cur_state == S_DONE) && (count != '0);
   // Oldest entry sits count slots behind the write pointer; a full buffer wraps onto wr_ptr itself.
   assign rd_ptr   = wr_ptr - count[PTR_W-1:0];
   assign rd_entry = mem[rd_ptr];
   assign rd_pc    = rd_valid ? rd_entry[ENT_W-1 -: DATA_W]       : '0;
   assign rd_op    = rd_valid ? rd_entry[DATA_W +: OP_W]          : '0;
   assign rd_alu   = rd_valid ? rd_entry[DATA_W-1:0]              : '0;

   // Next-state and per-cycle write/pop/decrement strobes; arm overrides everything.
   always_comb begin
      nxt_state = cur_state;
      wr_en     = 1'b0;
      pop       = 1'b0;
      post_dec  = 1'b0;
      if (arm) begin
         nxt_state = S_ARMED;
      end else begin
         case (cur_state)
            S_ARMED: begin
               if (sample_en) begin
                  wr_en = 1'b1;
                  if (!mode || (curPC == trig_pc))
                     nxt_state = (post_rem == '0) ? S_DONE : S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (sample_en) begin
                  wr_en    = 1'b1;
                  post_dec = 1'b1;
                  if (post_rem == CNT_W'(1))
                     nxt_state = S_DONE;
               end
            end
            S_DONE: begin
               pop = rd_valid && rd_ready;
            end
            default: ;
         endcase
      end
   end

   // State register.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)
         cur_state <= S_IDLE;
      else
         cur_state <= nxt_state;
   end

   // Pointer, occupancy, overflow and post-trigger bookkeeping.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         post_rem <= '0;
      end else if (arm) begin
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         post_rem <= post_count;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (full)
               overflow <= 1'b1;
            else
               count <= count + CNT_W'(1);
         end else if (pop) begin
            count <= count - CNT_W'(1);
         end
         if (post_dec)
            post_rem <= post_rem - CNT_W'(1);
      end
   end

   // Sample storage; contents are don't-care after reset so no reset is applied.
   always_ff @(posedge CLK) begin
      if (wr_en)
         mem[wr_ptr] <= {curPC, op, ALUData};
   end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - self-checking bench for cpu_trace_buffer with queue-based reference model
module tb_cpu_trace_buffer;

   localparam int DATA_W = 32;
   localparam int OP_W   = 6;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] alu;
   } entry_t;

   logic              CLK = 1'b0;
   logic              Reset;
   logic              arm;
   logic              mode;
   logic [DATA_W-1:0] trig_pc;
   logic [CNT_W-1:0]  post_count;
   logic              sample_en;
   logic [DATA_W-1:0] curPC;
   logic [OP_W-1:0]   op;
   logic [DATA_W-1:0] ALUData;
   logic              rd_ready;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_pc;
   logic [OP_W-1:0]   rd_op;
   logic [DATA_W-1:0] rd_alu;
   logic [CNT_W-1:0]  count;
   logic [1:0]        state;
   logic              overflow;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   cpu_trace_buffer #(.DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .Reset(Reset), .arm(arm), .mode(mode), .trig_pc(trig_pc),
      .post_count(post_count), .sample_en(sample_en), .curPC(curPC), .op(op),
      .ALUData(ALUData), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc),
      .rd_op(rd_op), .rd_alu(rd_alu), .count(count), .state(state), .overflow(overflow)
   );

   always #5 CLK = ~CLK;

   // Reference model: captured window as a queue, oldest at the front.
   entry_t mq[$];
   int     m_state = 0;
   int     m_prem  = 0;
   logic   m_ovf   = 1'b0;

   function automatic void m_push();
      entry_t e;
      e.pc  = curPC;
      e.op  = op;
      e.alu = ALUData;
      if (mq.size() == DEPTH) begin
         void'(mq.pop_front());
         m_ovf = 1'b1;
      end
      mq.push_back(e);
   endfunction

   always @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         mq.delete();
         m_state = 0;
         m_prem  = 0;
         m_ovf   = 1'b0;
      end else if (arm) begin
         mq.delete();
         m_state = 1;
         m_prem  = int'(post_count);
         m_ovf   = 1'b0;
      end else begin
         case (m_state)
            1: if (sample_en) begin
               m_push();
               if (!mode || curPC == trig_pc) m_state = (m_prem == 0) ? 3 : 2;
            end
            2: if (sample_en) begin
               m_push();
               m_prem = m_prem - 1;
               if (m_prem == 0) m_state = 3;
            end
            3: if (mq.size() > 0 && rd_ready) void'(mq.pop_front());
            default: ;
         endcase
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of all outputs against the model, away from the active edge.
   always @(negedge CLK) begin
      if (chk_en) begin
         logic              e_valid;
         entry_t            e;
         e_valid = (m_state == 3) && (mq.size() > 0);
         e = e_valid ? mq[0] : '0;
         chk("m_state",    64'(state),    64'(m_state));
         chk("m_count",    64'(count),    64'(mq.size()));
         chk("m_overflow", 64'(overflow), 64'(m_ovf));
         chk("m_rd_valid", 64'(rd_valid), 64'(e_valid));
         chk("m_rd_pc",    64'(rd_pc),    64'(e.pc));
         chk("m_rd_op",    64'(rd_op),    64'(e.op));
         chk("m_rd_alu",   64'(rd_alu),   64'(e.alu));
      end
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic do_arm(input logic m, input logic [DATA_W-1:0] tp, input int pc_n);
      mode       = m;
      trig_pc    = tp;
      post_count = CNT_W'(pc_n);
      arm        = 1'b1;
      step();
      arm        = 1'b0;
   endtask

   task automatic sample(input logic [DATA_W-1:0] pc);
      sample_en = 1'b1;
      curPC     = pc;
      op        = pc[7:2] ^ 6'h15;
      ALUData   = pc * 3 + 32'd1;
      step();
      sample_en = 1'b0;
   endtask

   task automatic drain(input int n, input logic [DATA_W-1:0] base, input logic [DATA_W-1:0] stp);
      for (int i = 0; i < n; i++) begin
         chk("drain_valid", 64'(rd_valid), 64'd1);
         chk("drain_pc", 64'(rd_pc), 64'(base + DATA_W'(i) * stp));
         rd_ready = 1'b1;
         step();
      end
      rd_ready = 1'b0;
   endtask

   initial begin
      logic [DATA_W-1:0] held_pc;
      Reset = 1'b0; arm = 1'b0; mode = 1'b0; trig_pc = '0; post_count = '0;
      sample_en = 1'b0; curPC = '0; op = '0; ALUData = '0; rd_ready = 1'b0;

      // 1: reset with random inputs
      for (int i = 0; i < 4; i++) begin
         arm = 1'($urandom); mode = 1'($urandom); trig_pc = $urandom;
         post_count = CNT_W'($urandom); sample_en = 1'($urandom);
         curPC = $urandom; op = OP_W'($urandom); ALUData = $urandom; rd_ready = 1'($urandom);
         step();
      end
      chk_en = 1'b1;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(rd_valid), 64'd0);
      chk("rst_pc", 64'(rd_pc), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      arm = 1'b0; sample_en = 1'b0; rd_ready = 1'b0; curPC = '0;
      Reset = 1'b1;
      step();
      sample(32'h10);
      chk("idle_ignores", 64'(count), 64'd0);

      // 2: immediate trigger, post 2
      do_arm(1'b0, '0, 2);
      sample(32'h00); sample(32'h04); sample(32'h08);
      chk("imm_state", 64'(state), 64'd3);
      chk("imm_count", 64'(count), 64'd3);
      drain(3, 32'h00, 32'h4);
      chk("imm_empty", 64'(rd_valid), 64'd0);
      chk("imm_done_hold", 64'(state), 64'd3);

      // 3: PC trigger with overflow
      do_arm(1'b1, 32'h20, 1);
      for (int i = 0; i < 10; i++) begin
         if (i == 8) chk("pc_armed", 64'(state), 64'd1);
         sample(DATA_W'(i * 4));
      end
      chk("pc_state", 64'(state), 64'd3);
      chk("pc_count", 64'(count), 64'd8);
      chk("pc_ovf", 64'(overflow), 64'd1);
      drain(8, 32'h08, 32'h4);

      // 4: post_count 0, DONE on trigger sample, later samples ignored
      do_arm(1'b1, 32'h0C, 0);
      sample(32'h00); sample(32'h04); sample(32'h08);
      chk("p0_not_yet", 64'(state), 64'd1);
      sample(32'h0C);
      chk("p0_state", 64'(state), 64'd3);
      sample(32'h10);
      chk("p0_count", 64'(count), 64'd4);
      drain(3, 32'h00, 32'h4);
      chk("p0_last_pc", 64'(rd_pc), 64'h0C);
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
      chk("p0_empty", 64'(count), 64'd0);

      // 5: drain with backpressure 1,0,1,1
      do_arm(1'b0, '0, 2);
      sample(32'h40); sample(32'h44); sample(32'h48);
      rd_ready = 1'b1; step();
      chk("bp_count1", 64'(count), 64'd2);
      rd_ready = 1'b0; held_pc = rd_pc;
      chk("bp_head", 64'(held_pc), 64'h44);
      step();
      chk("bp_stable", 64'(rd_pc), 64'(held_pc));
      chk("bp_count2", 64'(count), 64'd2);
      rd_ready = 1'b1; step(); step();
      rd_ready = 1'b0;
      chk("bp_count0", 64'(count), 64'd0);
      chk("bp_valid0", 64'(rd_valid), 64'd0);

      // 6a: re-arm mid-drain
      do_arm(1'b1, 32'h20, 1);
      for (int i = 0; i < 10; i++) sample(DATA_W'(i * 4));
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
      chk("rearm_pre", 64'(count), 64'd7);
      do_arm(1'b0, '0, 5);
      chk("rearm_state", 64'(state), 64'd1);
      chk("rearm_count", 64'(count), 64'd0);
      chk("rearm_ovf", 64'(overflow), 64'd0);

      // 6b: reset mid-capture
      sample(32'h100); sample(32'h104);
      chk("cap_state", 64'(state), 64'd2);
      Reset = 1'b0;
      #1;
      chk("rst_mid_state", 64'(state), 64'd0);
      chk("rst_mid_count", 64'(count), 64'd0);
      chk("rst_mid_ovf", 64'(overflow), 64'd0);
      step();
      Reset = 1'b1;
      step();
      step();

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
